mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Sits directly downstream of EX and feeds WB.
- Registers the EX→MEM bus and the EX HI/LO write bus, under stall/bubble control.
- Takes the synchronous data-SRAM read word and does load byte/half extraction with sign/zero extension.
- Produces the MEM→WB bus, plus MEM→ID forwarding buses for GPR and HI/LO.
- Holds the SRAM read word across stalls so a stalled load keeps a stable result.

Parameters:
- EX_TO_MEM_WD, 80, EX→MEM bus width: pc32, ram_en1, ram_wen4, sel_rf_res1, rf_we1, rf_waddr5, ex_result32, ram_read4.
- MEM_TO_WB_WD, 70, MEM→WB bus width: pc32, rf_we1, rf_waddr5, rf_wdata32.
- HILO_WD, 66, HI/LO bus width: hi_we1, lo_we1, hi32, lo32.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  6  pipeline stall vector; bit3 = MEM input, bit4 = WB input.
- ex_to_mem_bus  in  80  from EX, field order as in EX_TO_MEM_WD.
- ex_to_mem_hilo  in  66  HI/LO write request from EX.
- data_sram_rdata  in  32  SRAM read word; valid the cycle after EX drove the address.
- mem_to_wb_bus  out  70  to WB.
- mem_to_wb_hilo  out  66  registered HI/LO request passed on to WB.
- mem_to_id_bus  out  38  {rf_we, rf_waddr, rf_wdata} for forwarding.
- mem_to_id_hilo  out  66  HI/LO forwarding copy.
- stallreq_for_mem  out  1  stall request to the controller.

Behaviour:
- Input register (holds both buses):
  - rst → all zero.
  - stall[3]=Stop and stall[4]=NoStop → zero (bubble).
  - stall[3]=NoStop → capture.
  - Otherwise hold.
- Read-word hold register, rdata_hold, with flag hold_vld:
  - hold_vld clears on every input-register update, bubble or capture.
  - In the first MEM cycle after a capture, if stall[4]=Stop, latch data_sram_rdata into rdata_hold and set hold_vld.
  - Effective read word = hold_vld ? rdata_hold : data_sram_rdata.
  - rst clears both.
- ram_read encoding (shared package): 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 SB, 0111 SH, 0000 word/none.
- Byte loads select the lane by ex_result[1:0].
- Half-word loads select the lane by ex_result[1]; ex_result[0] is ignored, no exception.
- LB/LH sign-extend; LBU/LHU zero-extend.
- A load with ram_read 0000 (LW) uses the full word.
- rf_wdata = sel_rf_res ? extended load data : ex_result.
- Stores (ram_wen≠0) pass rf_we through unchanged; rf_we is 0 from decode.
- The forwarding buses carry the same values as the WB buses in the same cycle, combinationally from the MEM register.
- A bubble gives rf_we=0, hi_we=lo_we=0 and pc=0.
- Latency: one cycle from EX issue to the mem_to_wb_bus value.
- All outputs are 0 while rst is high and in the cycle after reset.
- Reset mid-stall discards the held word.
- Base build: stallreq_for_mem is constant 0.

Optional Feature:
- Macro: MEM_SRAM_WAIT_EN.
- When defined:
  - Adds input data_sram_rvalid (1 bit).
  - Adds FSM IDLE/WAIT:
    - IDLE→WAIT when the register holds a load (ram_en=1, ram_wen=0) and rvalid=0.
    - WAIT→IDLE when rvalid=1. That word is latched into rdata_hold with hold_vld=1.
  - stallreq_for_mem = 1 in WAIT, and in IDLE on a load cycle with rvalid=0.
  - rst→IDLE.
  - A bubble or capture forces IDLE.
- When undefined: no rvalid port, no FSM, stallreq_for_mem = 0.

Decomposition:
- Shared defines package gets:
  - the three bus widths;
  - the ram_read codes;
  - Stop/NoStop.
- One sub-module, load_ext: purely combinational {ram_read, addr[1:0], word} → 32-bit extended data.

Test Plan:
- LB at addr 0x..01, rdata 0x1234_80FF, sel_rf_res=1 → rf_wdata 0xFFFF_FF80. LBU gives 0x0000_0080.
- LH at addr 0x..02, rdata 0x8001_7FFF → rf_wdata 0xFFFF_8001. LHU gives 0x0000_8001. Addr 0x..03 gives the same (bit0 ignored).
- ALU op: ex_result 0xDEAD_BEEF, sel_rf_res=0, rf_we=1, waddr 5 → WB and ID buses show {1, 5, 0xDEADBEEF} one cycle after issue.
- stall[3]=1, stall[4]=0 → next cycle rf_we=0, HI/LO we=0, pc=0.
- LW captured, then stall[4]=1 for 3 cycles while rdata changes 0x11111111→0x22222222 → rf_wdata stays 0x11111111 throughout.
- MEM_SRAM_WAIT_EN: load with rvalid low 2 cycles, then high with 0xCAFEBABE → stallreq_for_mem high exactly 2 cycles, then rf_wdata 0xCAFEBABE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared bus widths, load codes, stall levels and bus layouts for the MEM stage
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 80;
    localparam int MEM_TO_WB_WD = 70;
    localparam int HILO_WD      = 66;

    localparam logic [3:0] RD_WORD = 4'b0000;
    localparam logic [3:0] RD_LB   = 4'b0001;
    localparam logic [3:0] RD_LBU  = 4'b0010;
    localparam logic [3:0] RD_LH   = 4'b0011;
    localparam logic [3:0] RD_LHU  = 4'b0100;
    localparam logic [3:0] RD_SB   = 4'b0101;
    localparam logic [3:0] RD_SH   = 4'b0111;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
        logic [3:0]  ram_read;
    } ex_mem_t;

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    typedef enum logic {S_IDLE, S_WAIT} wait_st_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX->MEM, MEM->WB and MEM->ID buses of the MEM stage; MEM_SRAM_WAIT_EN adds the SRAM read-valid
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [5:0]              stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [HILO_WD-1:0]      ex_to_mem_hilo;
    logic [31:0]             data_sram_rdata;
`ifdef MEM_SRAM_WAIT_EN
    logic                    data_sram_rvalid;
`endif
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [HILO_WD-1:0]      mem_to_wb_hilo;
    logic [37:0]             mem_to_id_bus;
    logic [HILO_WD-1:0]      mem_to_id_hilo;
    logic                    stallreq_for_mem;

`ifdef MEM_SRAM_WAIT_EN
    modport master (
        output stall, ex_to_mem_bus, ex_to_mem_hilo, data_sram_rdata, data_sram_rvalid,
        input  mem_to_wb_bus, mem_to_wb_hilo, mem_to_id_bus, mem_to_id_hilo, stallreq_for_mem
    );
    modport slave (
        input  stall, ex_to_mem_bus, ex_to_mem_hilo, data_sram_rdata, data_sram_rvalid,
        output mem_to_wb_bus, mem_to_wb_hilo, mem_to_id_bus, mem_to_id_hilo, stallreq_for_mem
    );
`else
    modport master (
        output stall, ex_to_mem_bus, ex_to_mem_hilo, data_sram_rdata,
        input  mem_to_wb_bus, mem_to_wb_hilo, mem_to_id_bus, mem_to_id_hilo, stallreq_for_mem
    );
    modport slave (
        input  stall, ex_to_mem_bus, ex_to_mem_hilo, data_sram_rdata,
        output mem_to_wb_bus, mem_to_wb_hilo, mem_to_id_bus, mem_to_id_hilo, stallreq_for_mem
    );
`endif

endinterface

// File: rtl/mem_stage_load_ext.sv
// mem_stage_load_ext: picks the byte/half lane of a load word and sign- or zero-extends it
module mem_stage_load_ext
    import mem_stage_pkg::*;
(
    input  logic [3:0]  ram_read,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = word[{addr, 3'b000} +: 8];
    assign h = addr[1] ? word[31:16] : word[15:0];

    // unknown codes and stores fall through to the full word
    always_comb
        data = (ram_read == RD_LB)  ? {{24{b[7]}}, b} :
               (ram_read == RD_LBU) ? {24'b0, b} :
               (ram_read == RD_LH)  ? {{16{h[15]}}, h} :
               (ram_read == RD_LHU) ? {16'b0, h} : word;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage - EX/MEM register, load extension, read-word hold; MEM_SRAM_WAIT_EN adds an SRAM wait FSM
module mem_stage
    import mem_stage_pkg::*;
(
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);

    ex_mem_t     r;
    hilo_t       h;
    logic [31:0] rdata_hold, rdata, ld_data, wdata;
    logic        hold_vld, fresh, latch_en;
    logic        capture, bubble, upd;

    assign capture = bus.stall[3] == NO_STOP;
    assign bubble  = bus.stall[3] == STOP && bus.stall[4] == NO_STOP;
    assign upd     = capture || bubble;

    // EX/MEM register: zero on reset or bubble, capture when MEM input runs, else hold
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            r <= '0;
            h <= '0;
        end else if (capture) begin
            r <= ex_mem_t'(bus.ex_to_mem_bus);
            h <= hilo_t'(bus.ex_to_mem_hilo);
        end
    end

`ifdef MEM_SRAM_WAIT_EN
    wait_st_t st;
    logic     miss;

    assign miss = r.ram_en && r.ram_wen == 4'b0 && !hold_vld && !bus.data_sram_rvalid;
    assign latch_en = (st == S_WAIT) ? bus.data_sram_rvalid : fresh && bus.stall[4] == STOP && !miss;
    assign bus.stallreq_for_mem = !rst && miss;

    // wait for the SRAM word of a held load; any register update abandons the wait
    always_ff @(posedge clk)
        st <= (rst || upd) ? S_IDLE :
              (st == S_IDLE && miss) ? S_WAIT :
              (st == S_WAIT && bus.data_sram_rvalid) ? S_IDLE : st;
`else
    assign latch_en = fresh && bus.stall[4] == STOP;
    assign bus.stallreq_for_mem = 1'b0;
`endif

    // keep the read word of a stalled load so its result stays stable
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld   <= 1'b0;
            fresh      <= 1'b0;
            rdata_hold <= '0;
        end else if (upd) begin
            hold_vld <= 1'b0;
            fresh    <= capture;
        end else begin
            fresh <= 1'b0;
            if (latch_en) begin
                rdata_hold <= bus.data_sram_rdata;
                hold_vld   <= 1'b1;
            end
        end
    end

    assign rdata = hold_vld ? rdata_hold : bus.data_sram_rdata;

    mem_stage_load_ext u_ext (
        .ram_read (r.ram_read),
        .addr     (r.ex_result[1:0]),
        .word     (rdata),
        .data     (ld_data)
    );

    assign wdata              = r.sel_rf_res ? ld_data : r.ex_result;
    assign bus.mem_to_wb_bus  = rst ? '0 : {r.pc, r.rf_we, r.rf_waddr, wdata};
    assign bus.mem_to_id_bus  = bus.mem_to_wb_bus[37:0];
    assign bus.mem_to_wb_hilo = rst ? '0 : h;
    assign bus.mem_to_id_hilo = bus.mem_to_wb_hilo;

    logic unused;
    assign unused = ^{bus.stall[5], bus.stall[2:0], r.ram_en, r.ram_wen};

endmodule
